// File: rtl/discharge_fsm.sv
// -----------------------------------------------------------------------------
// discharge_fsm
//
// Pulse-sequencing state machine for the EDM discharge channel. It sits right
// after the breakdown detector: it consumes is_breakdown and feeds the
// detector's current_state and timer_wait_breakdown inputs. Each pulse runs
// wait-for-breakdown, then discharge (two-phase interleaved buck or resistor),
// then deionisation. The waveform word selects continuous or single-shot
// operation.
//
// Ports
//   clk                  100 MHz system clock
//   rst                  asynchronous active-high reset
//   is_breakdown         breakdown flag from the detector
//   waveform[15:0]       bit15 buck(1)/resistor(0), bit14 continuous(1)/single(0),
//                        bit13 enable; the remaining bits are ignored
//   single_trigger       one-cycle start pulse, only used in single mode
//   ton_cycles[15:0]     discharge on-time in clocks (0 behaves as 1)
//   toff_cycles[15:0]    deionisation time in clocks (0 behaves as 1)
//   wait_timeout_cycles  open-gap timeout in clocks (0 disables it)
//   current_state[7:0]   state code shown to the detector
//   timer_wait_breakdown clocks spent in the current/last wait phase
//   gate_wait            gap-voltage switch
//   gate_buck_a/_b       interleaved buck phase switches
//   gate_res             resistor discharge switch
//   pulse_count          completed discharges
//   timeout_count        open-gap timeouts
// -----------------------------------------------------------------------------
module discharge_fsm #(
   parameter logic [31:0] MIN_WAIT_CYCLES = 32'd400,
   parameter logic [15:0] PHASE_CYCLES    = 16'd50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_breakdown,
   input  logic [15:0] waveform,
   input  logic        single_trigger,
   input  logic [15:0] ton_cycles,
   input  logic [15:0] toff_cycles,
   input  logic [31:0] wait_timeout_cycles,
   output logic [7:0]  current_state,
   output logic [31:0] timer_wait_breakdown,
   output logic        gate_wait,
   output logic        gate_buck_a,
   output logic        gate_buck_b,
   output logic        gate_res,
   output logic [31:0] pulse_count,
   output logic [31:0] timeout_count
);

   localparam logic [7:0] S_DEION             = 8'b1000_0000;
   localparam logic [7:0] S_DEION_SINGLE_BUCK = 8'b0000_0000;
   localparam logic [7:0] S_WAIT_BREAKDOWN    = 8'b0000_0001;
   localparam logic [7:0] S_BUCK_INTERLEAVE   = 8'b0000_0010;
   localparam logic [7:0] S_RES_DISCHARGE     = 8'b0000_0100;

   logic [7:0]  r_state;
   logic [1:0]  r_wfQ;
   logic [31:0] r_timer;
   logic [15:0] r_onCnt;
   logic [15:0] r_offCnt;
   logic [15:0] r_phaseCnt;
   logic        r_phaseB;
   logic        r_gateWait;
   logic        r_gateA;
   logic        r_gateB;
   logic        r_gateRes;
   logic [31:0] r_pulseCount;
   logic [31:0] r_timeoutCount;

   logic [7:0]  w_nextState;
   logic        w_enable;
   logic        w_pulseDone;
   logic        w_timeout;
   logic [15:0] w_tonLast;
   logic [15:0] w_toffLast;
   logic [15:0] w_phaseCntNext;
   logic        w_phaseBNext;
   logic        w_unusedWaveform;

   assign w_enable         = waveform[13];
   assign w_unusedWaveform = ^waveform[12:0];

   // Zero on-time or off-time is treated as a single clock, so the terminal
   // count is max(x,1)-1.
   assign w_tonLast  = (ton_cycles  == 16'd0) ? 16'd0 : ton_cycles  - 16'd1;
   assign w_toffLast = (toff_cycles == 16'd0) ? 16'd0 : toff_cycles - 16'd1;

   // Next-state decision. Enable loss always wins. In the wait state a valid
   // breakdown outranks the open-gap timeout, and a breakdown seen before the
   // minimum wait is ignored so the voltage rise slope is not mistaken for one.
   always_comb begin
      w_nextState = r_state;
      w_pulseDone = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_DEION_SINGLE_BUCK: begin
            if (w_enable && (waveform[14] || single_trigger))
               w_nextState = S_WAIT_BREAKDOWN;
         end
         S_WAIT_BREAKDOWN: begin
            if (!w_enable) begin
               w_nextState = S_DEION;
            end else if (is_breakdown && (r_timer >= MIN_WAIT_CYCLES)) begin
               w_nextState = r_wfQ[1] ? S_BUCK_INTERLEAVE : S_RES_DISCHARGE;
            end else if ((wait_timeout_cycles != 32'd0) &&
                         (r_timer == wait_timeout_cycles - 32'd1)) begin
               w_nextState = S_DEION;
               w_timeout   = 1'b1;
            end
         end
         S_BUCK_INTERLEAVE, S_RES_DISCHARGE: begin
            if (!w_enable) begin
               w_nextState = S_DEION;
            end else if (r_onCnt == w_tonLast) begin
               w_nextState = S_DEION;
               w_pulseDone = 1'b1;
            end
         end
         S_DEION: begin
            if (r_offCnt == w_toffLast)
               w_nextState = (w_enable && r_wfQ[0]) ? S_WAIT_BREAKDOWN
                                                    : S_DEION_SINGLE_BUCK;
         end
         default: begin
            w_nextState = S_DEION;
         end
      endcase
   end

   // Buck interleave phase tracking. Every entry into the buck state restarts
   // on phase A; after PHASE_CYCLES clocks the active leg toggles. Gates are
   // derived from a single phase bit so A and B can never overlap.
   always_comb begin
      w_phaseCntNext = 16'd0;
      w_phaseBNext   = 1'b0;
      if (r_state == S_BUCK_INTERLEAVE) begin
         if (r_phaseCnt == PHASE_CYCLES - 16'd1) begin
            w_phaseCntNext = 16'd0;
            w_phaseBNext   = ~r_phaseB;
         end else begin
            w_phaseCntNext = r_phaseCnt + 16'd1;
            w_phaseBNext   = r_phaseB;
         end
      end
   end

   // State register and everything that must change on the same edge as it.
   // Gates are computed from the next state so the outputs always agree with
   // the state being shown. Reset drops every gate immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_DEION;
         r_wfQ          <= 2'b00;
         r_timer        <= 32'd0;
         r_onCnt        <= 16'd0;
         r_offCnt       <= 16'd0;
         r_phaseCnt     <= 16'd0;
         r_phaseB       <= 1'b0;
         r_gateWait     <= 1'b0;
         r_gateA        <= 1'b0;
         r_gateB        <= 1'b0;
         r_gateRes      <= 1'b0;
         r_pulseCount   <= 32'd0;
         r_timeoutCount <= 32'd0;
      end else begin
         r_state <= w_nextState;

         if (w_nextState == S_WAIT_BREAKDOWN) begin
            if (r_state != S_WAIT_BREAKDOWN) begin
               r_timer <= 32'd0;
               r_wfQ   <= waveform[15:14];
            end else if (r_timer != 32'hFFFF_FFFF) begin
               r_timer <= r_timer + 32'd1;
            end
         end

         if ((w_nextState == r_state) &&
             ((r_state == S_BUCK_INTERLEAVE) || (r_state == S_RES_DISCHARGE)))
            r_onCnt <= r_onCnt + 16'd1;
         else
            r_onCnt <= 16'd0;

         if ((w_nextState == r_state) && (r_state == S_DEION))
            r_offCnt <= r_offCnt + 16'd1;
         else
            r_offCnt <= 16'd0;

         if (w_nextState == S_BUCK_INTERLEAVE) begin
            r_phaseCnt <= w_phaseCntNext;
            r_phaseB   <= w_phaseBNext;
         end

         r_gateWait <= (w_nextState == S_WAIT_BREAKDOWN);
         r_gateA    <= (w_nextState == S_BUCK_INTERLEAVE) && !w_phaseBNext;
         r_gateB    <= (w_nextState == S_BUCK_INTERLEAVE) &&  w_phaseBNext;
         r_gateRes  <= (w_nextState == S_RES_DISCHARGE);

         if (w_pulseDone)
            r_pulseCount <= r_pulseCount + 32'd1;
         if (w_timeout)
            r_timeoutCount <= r_timeoutCount + 32'd1;
      end
   end

   assign current_state        = r_state;
   assign timer_wait_breakdown = r_timer;
   assign gate_wait            = r_gateWait;
   assign gate_buck_a          = r_gateA;
   assign gate_buck_b          = r_gateB;
   assign gate_res             = r_gateRes;
   assign pulse_count          = r_pulseCount;
   assign timeout_count        = r_timeoutCount;

endmodule

// File: tb/tb_discharge_fsm.sv
// -----------------------------------------------------------------------------
// tb_discharge_fsm
//
// Self-checking bench for discharge_fsm. A behavioural model tracks which
// phase of the pulse the channel is in and how long it has been there, and
// derives every output from that; a compare process checks the DUT against it
// on every falling edge. Directed stimulus walks through reset, continuous
// buck, early breakdown, open-gap timeout, enable loss, single-shot resistor
// and asynchronous reset, with literal expectations at the key points.
// -----------------------------------------------------------------------------
module tb_discharge_fsm;

   localparam int MIN_WAIT = 400;
   localparam int PHASE    = 50;

   localparam int M_DEION = 0;
   localparam int M_IDLE  = 1;
   localparam int M_WAIT  = 2;
   localparam int M_BUCK  = 3;
   localparam int M_RES   = 4;

   logic        clk;
   logic        rst;
   logic        is_breakdown;
   logic [15:0] waveform;
   logic        single_trigger;
   logic [15:0] ton_cycles;
   logic [15:0] toff_cycles;
   logic [31:0] wait_timeout_cycles;
   logic [7:0]  current_state;
   logic [31:0] timer_wait_breakdown;
   logic        gate_wait;
   logic        gate_buck_a;
   logic        gate_buck_b;
   logic        gate_res;
   logic [31:0] pulse_count;
   logic [31:0] timeout_count;

   int tests = 0;
   int fails = 0;

   discharge_fsm dut (
      .clk                  (clk),
      .rst                  (rst),
      .is_breakdown         (is_breakdown),
      .waveform             (waveform),
      .single_trigger       (single_trigger),
      .ton_cycles           (ton_cycles),
      .toff_cycles          (toff_cycles),
      .wait_timeout_cycles  (wait_timeout_cycles),
      .current_state        (current_state),
      .timer_wait_breakdown (timer_wait_breakdown),
      .gate_wait            (gate_wait),
      .gate_buck_a          (gate_buck_a),
      .gate_buck_b          (gate_buck_b),
      .gate_res             (gate_res),
      .pulse_count          (pulse_count),
      .timeout_count        (timeout_count)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: which pulse phase we are in, how many clocks have
   // already been spent in it, the latched mode bits and the two tallies.
   int          mState    = M_DEION;
   int          mNext;
   longint      mElapsed  = 0;
   longint      mTimer    = 0;
   logic [1:0]  mWf       = 2'b00;
   logic [31:0] mPulses   = 32'd0;
   logic [31:0] mTimeouts = 32'd0;
   longint      mTon;
   longint      mToff;
   longint      mTmo;

   function automatic logic [7:0] codeOf(input int s);
      case (s)
         M_IDLE:  return 8'h00;
         M_WAIT:  return 8'h01;
         M_BUCK:  return 8'h02;
         M_RES:   return 8'h04;
         default: return 8'h80;
      endcase
   endfunction

   // Advance the model one clock using the inputs that the DUT sees.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mState    = M_DEION;
         mElapsed  = 0;
         mTimer    = 0;
         mWf       = 2'b00;
         mPulses   = 32'd0;
         mTimeouts = 32'd0;
      end else begin
         mTon  = (ton_cycles  == 16'd0) ? 1 : longint'(ton_cycles);
         mToff = (toff_cycles == 16'd0) ? 1 : longint'(toff_cycles);
         mTmo  = longint'(wait_timeout_cycles);
         mNext = mState;
         case (mState)
            M_IDLE:
               if (waveform[13] && (waveform[14] || single_trigger)) mNext = M_WAIT;
            M_WAIT:
               if (!waveform[13]) mNext = M_DEION;
               else if (is_breakdown && mTimer >= MIN_WAIT) mNext = mWf[1] ? M_BUCK : M_RES;
               else if (mTmo != 0 && mTimer + 1 == mTmo) begin
                  mNext = M_DEION;
                  mTimeouts = mTimeouts + 32'd1;
               end
            M_BUCK, M_RES:
               if (!waveform[13]) mNext = M_DEION;
               else if (mElapsed + 1 == mTon) begin
                  mNext = M_DEION;
                  mPulses = mPulses + 32'd1;
               end
            default:
               if (mElapsed + 1 == mToff) mNext = (waveform[13] && mWf[0]) ? M_WAIT : M_IDLE;
         endcase
         if (mNext != mState) begin
            mElapsed = 0;
            if (mNext == M_WAIT) begin
               mTimer = 0;
               mWf    = waveform[15:14];
            end
         end else begin
            mElapsed = mElapsed + 1;
            if (mState == M_WAIT && mTimer != 64'h0000_0000_FFFF_FFFF) mTimer = mTimer + 1;
         end
         mState = mNext;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      checkOutput("model state", {24'd0, current_state}, {24'd0, codeOf(mState)});
      checkOutput("model timer", timer_wait_breakdown, mTimer[31:0]);
      checkOutput("model gate_wait", {31'd0, gate_wait}, {31'd0, mState == M_WAIT});
      checkOutput("model gate_a", {31'd0, gate_buck_a},
                  {31'd0, (mState == M_BUCK) && ((mElapsed / PHASE) % 2 == 0)});
      checkOutput("model gate_b", {31'd0, gate_buck_b},
                  {31'd0, (mState == M_BUCK) && ((mElapsed / PHASE) % 2 == 1)});
      checkOutput("model gate_res", {31'd0, gate_res}, {31'd0, mState == M_RES});
      checkOutput("model pulses", pulse_count, mPulses);
      checkOutput("model timeouts", timeout_count, mTimeouts);
   end

   task automatic applyStimulus(input logic [15:0] wf, input logic [15:0] ton,
                                input logic [15:0] toff, input logic [31:0] tmo);
      waveform            = wf;
      ton_cycles          = ton;
      toff_cycles         = toff;
      wait_timeout_cycles = tmo;
   endtask

   // Bounded wait for a state; running out of budget shows up as a failed check.
   task automatic waitState(input logic [7:0] code, input int budget);
      int n;
      n = 0;
      while (current_state !== code && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("waitState", {24'd0, current_state}, {24'd0, code});
   endtask

   task automatic pulseTrigger();
      single_trigger = 1'b1;
      @(negedge clk);
      single_trigger = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      is_breakdown   = 1'b0;
      single_trigger = 1'b0;
      applyStimulus(16'hE000, 16'd200, 16'd0, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("reset state", {24'd0, current_state}, 32'h80);
      checkOutput("reset gates", {28'd0, gate_wait, gate_buck_a, gate_buck_b, gate_res}, 32'd0);
      rst = 1'b0;

      // Reset release: one deion clock, one idle clock, then waiting
      @(negedge clk);
      checkOutput("post-reset idle", {24'd0, current_state}, 32'h00);
      @(negedge clk);
      checkOutput("enter wait", {24'd0, current_state}, 32'h01);
      checkOutput("wait gate", {31'd0, gate_wait}, 32'd1);
      checkOutput("timer 0", timer_wait_breakdown, 32'd0);
      @(negedge clk);
      checkOutput("timer 1", timer_wait_breakdown, 32'd1);
      @(negedge clk);
      checkOutput("timer 2", timer_wait_breakdown, 32'd2);
      toff_cycles = 16'd300;

      // Continuous buck pulse
      repeat (498) @(negedge clk);
      checkOutput("timer 500", timer_wait_breakdown, 32'd500);
      is_breakdown = 1'b1;
      @(negedge clk);
      is_breakdown = 1'b0;
      checkOutput("buck entered", {24'd0, current_state}, 32'h02);
      checkOutput("phase A first", {30'd0, gate_buck_a, gate_buck_b}, 32'b10);
      repeat (50) @(negedge clk);
      checkOutput("phase B", {30'd0, gate_buck_a, gate_buck_b}, 32'b01);
      repeat (150) @(negedge clk);
      checkOutput("deion after 200", {24'd0, current_state}, 32'h80);
      checkOutput("pulse count 1", pulse_count, 32'd1);
      repeat (300) @(negedge clk);
      checkOutput("rewait after 300", {24'd0, current_state}, 32'h01);
      checkOutput("rewait timer", timer_wait_breakdown, 32'd0);

      // Early breakdown is held off until the minimum wait
      repeat (100) @(negedge clk);
      is_breakdown = 1'b1;
      repeat (299) @(negedge clk);
      checkOutput("early bd 399", {24'd0, current_state}, 32'h01);
      @(negedge clk);
      checkOutput("early bd 400", {24'd0, current_state}, 32'h01);
      @(negedge clk);
      is_breakdown = 1'b0;
      checkOutput("early bd taken", {24'd0, current_state}, 32'h02);
      waitState(8'h80, 300);
      waitState(8'h01, 400);
      checkOutput("pulse count 2", pulse_count, 32'd2);

      // Open-gap timeout, then breakdown coinciding with the timeout
      wait_timeout_cycles = 32'd1000;
      waitState(8'h80, 1100);
      checkOutput("timeout count 1", timeout_count, 32'd1);
      checkOutput("timer held 999", timer_wait_breakdown, 32'd999);
      waitState(8'h01, 400);
      repeat (999) @(negedge clk);
      is_breakdown = 1'b1;
      @(negedge clk);
      is_breakdown = 1'b0;
      wait_timeout_cycles = 32'd0;
      checkOutput("bd beats timeout", {24'd0, current_state}, 32'h02);
      checkOutput("timeout unchanged", timeout_count, 32'd1);

      // Enable dropped five clocks into the buck pulse
      repeat (5) @(negedge clk);
      waveform = 16'hC000;
      @(negedge clk);
      checkOutput("abort deion", {24'd0, current_state}, 32'h80);
      checkOutput("abort gates", {28'd0, gate_wait, gate_buck_a, gate_buck_b, gate_res}, 32'd0);
      waitState(8'h00, 400);
      checkOutput("abort no pulse", pulse_count, 32'd2);

      // Single-shot resistor pulse
      applyStimulus(16'h2000, 16'd10, 16'd300, 32'd0);
      repeat (20) @(negedge clk);
      checkOutput("single idle", {24'd0, current_state}, 32'h00);
      pulseTrigger();
      checkOutput("single wait", {24'd0, current_state}, 32'h01);
      repeat (400) @(negedge clk);
      is_breakdown = 1'b1;
      @(negedge clk);
      is_breakdown = 1'b0;
      checkOutput("res on", {31'd0, gate_res}, 32'd1);
      repeat (9) @(negedge clk);
      checkOutput("res clock 10", {31'd0, gate_res}, 32'd1);
      @(negedge clk);
      checkOutput("res off", {24'd0, current_state, gate_res} >> 1, 32'h80);
      checkOutput("pulse count 3", pulse_count, 32'd3);
      waitState(8'h00, 400);
      repeat (50) @(negedge clk);
      checkOutput("single stays idle", {24'd0, current_state}, 32'h00);
      pulseTrigger();
      checkOutput("second trigger", {24'd0, current_state}, 32'h01);

      // Asynchronous reset in the middle of the wait phase
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async state", {24'd0, current_state}, 32'h80);
      checkOutput("async gate_wait", {31'd0, gate_wait}, 32'd0);
      checkOutput("async counters", pulse_count | timer_wait_breakdown, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
